// File: rtl/ex_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit for the execute stage.
// Radix-2 restoring divider, 32 iterations; divide-by-zero and signed overflow finish in one cycle.
module ex_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            start,
  input  logic [1:0]      divop,
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   dvd, dvs, rem;
  logic [4:0]        cnt;
  logic              is_rem, q_neg, r_neg;

  // divop[0]=0 selects the signed forms, divop[1]=1 selects remainder
  logic              sgn_op, accept, div_zero, sgn_ovf, special, last;
  logic [XLEN-1:0]   shifted, rem_nxt, quo_nxt;
  logic [XLEN:0]     diff;

  assign sgn_op   = ~divop[0];
  assign accept   = (state == IDLE) & start & ~flush;
  assign div_zero = (opr_b == '0);
  assign sgn_ovf  = sgn_op & (opr_a == {1'b1, {(XLEN-1){1'b0}}}) & (opr_b == '1);
  assign special  = div_zero | sgn_ovf;
  assign last     = (cnt == 5'd31);

  assign shifted  = {rem[XLEN-2:0], dvd[XLEN-1]};
  assign diff     = {1'b0, shifted} - {1'b0, dvs};
  assign rem_nxt  = diff[XLEN] ? shifted : diff[XLEN-1:0];
  assign quo_nxt  = {dvd[XLEN-2:0], ~diff[XLEN]};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      is_rem <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      is_rem <= divop[1];
      dvd    <= (sgn_op & opr_a[XLEN-1]) ? -opr_a : opr_a;
      dvs    <= (sgn_op & opr_b[XLEN-1]) ? -opr_b : opr_b;
      q_neg  <= sgn_op & (opr_a[XLEN-1] ^ opr_b[XLEN-1]);
      r_neg  <= sgn_op & opr_a[XLEN-1];
      rem    <= '0;
      cnt    <= '0;
      if (div_zero)
        result <= divop[1] ? opr_a : '1;
      else if (sgn_ovf)
        result <= divop[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else if (state == CALC && !flush) begin
      dvd <= quo_nxt;
      rem <= rem_nxt;
      cnt <= cnt + 5'd1;
      if (last) begin
        if (is_rem) result <= r_neg ? -rem_nxt : rem_nxt;
        else        result <= q_neg ? -quo_nxt : quo_nxt;
      end
    end
  end

  assign stall = accept | (state == CALC);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: results, latency, stall window, flush and async reset.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start, flush;
  logic [1:0]  divop;
  logic [31:0] opr_a, opr_b;
  logic        stall, busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  ex_div_unit #(.XLEN(32)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .divop(divop),
    .opr_a(opr_a), .opr_b(opr_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one op one step after an edge; hold start until the done cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int cyc = 0;
    int stl = 0;
    start = 1'b1; divop = op; opr_a = a; opr_b = b;
    #1;
    if (stall) stl++;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      if (stall) stl++;
    end
    chk({tag, " done_seen"}, 32'(done), 32'd1);
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " stall_cycles"}, stl, exp_lat);
    chk({tag, " stall_in_done"}, 32'(stall), 32'd0);
    chk({tag, " busy_in_done"}, 32'(busy), 32'd1);
    chk({tag, " result"}, result, exp_res);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
    chk({tag, " result_hold"}, result, exp_res);
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; flush = 1'b0; divop = OP_DIV; opr_a = '0; opr_b = '0;
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst result", result, 32'd0);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;

    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("div -7/2",  OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem -7/2",  OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("rem 7/-2",  OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("div 100/-7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    run_op("remu big/16", OP_REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, 33);
    run_op("divu x/0",  OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem x/0",   OP_REM, 32'h1234, 32'd0, 32'h1234, 1);
    run_op("div min/0", OP_DIV, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("div ovf",   OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf",   OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu ovf",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // flush in CALC cycle 10: aborts with no done, result untouched
    start = 1'b1; divop = OP_DIVU; opr_a = 32'd1000; opr_b = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    chk("flush pre busy", 32'(busy), 32'd1);
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush stall", 32'(stall), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    begin
      int seen = 0;
      repeat (30) begin @(posedge clk); #1; if (done || busy) seen++; end
      chk("flush no done", seen, 0);
    end
    chk("flush result", result, 32'd0);
    run_op("divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // async reset in CALC cycle 20
    start = 1'b1; divop = OP_DIVU; opr_a = 32'd77; opr_b = 32'd5;
    repeat (20) begin @(posedge clk); #1; end
    arst_n = 1'b0; start = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst done", 32'(done), 32'd0);
    chk("arst stall", 32'(stall), 32'd0);
    chk("arst result", result, 32'd0);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst still idle", 32'(busy), 32'd0);
    run_op("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative RV32M divide/remainder unit that sits beside the ALU in the execute stage. It is sequenced by its own FSM and holds the EX stage through a stall output while it works. Normal operations take 32 iterations using a radix-2 restoring algorithm. Divide-by-zero and signed overflow are resolved in one cycle, and pipeline flushes abort the operation cleanly.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk` in 1: clock. All flops are rising-edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `start` in 1: EX holds a valid div/rem instruction. Level signal, held by EX while stalled.
- `divop` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `opr_a` in 32: dividend (post-forwarding `opr_a`).
- `opr_b` in 32: divisor (post-forwarding `opr_b`).
- `flush` in 1: branch/trap flush of EX. Aborts the operation.
- `stall` out 1: holds IF/ID/EX. Combinational.
- `busy` out 1: FSM is not in IDLE.
- `done` out 1: one-cycle pulse; `result` is valid in this cycle.
- `result` out 32: quotient or remainder, registered.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE, accepting an operation** (`start` & ~`flush`):
  - Latch `divop`.
  - Signed ops: latch `abs(opr_a)` → dividend, `abs(opr_b)` → divisor; `q_neg = a[31]^b[31]`, `r_neg = a[31]`.
  - Unsigned ops: latch raw operands; `q_neg = r_neg = 0`.
  - Clear `rem` and `cnt`.
- **Special cases, decided in IDLE:**
  - `opr_b == 0`: quotient = 0xFFFFFFFF, remainder = `opr_a`. Go to DONE.
  - Signed op with `opr_a == 0x80000000` and `opr_b == 0xFFFFFFFF`: quotient = 0x80000000, remainder = 0. Go to DONE.
  - Otherwise go to CALC.
- **CALC, per cycle:**
  - `shifted = {rem[30:0], dvd[31]}`.
  - `diff = {1'b0, shifted} - {1'b0, dvs}` (33 bits).
  - If `diff[32] == 0`: `rem = diff[31:0]` and the quotient bit is 1. Otherwise `rem = shifted` and the quotient bit is 0.
  - `dvd = {dvd[30:0], qbit}`; the dividend register becomes the quotient.
  - `cnt++`. When `cnt == 31`, go to DONE.
- **Entering DONE:**
  - `result` = quotient (negated if `q_neg`) for DIV/DIVU.
  - `result` = `rem` (negated if `r_neg`) for REM/REMU.
  - Negation is two's complement, modulo 2^32.
- **DONE:** `done = 1`. Always go to IDLE next cycle. `result` holds until the next DONE.
- **`stall`** = (IDLE & `start` & ~`flush`) | CALC. It is low in DONE so EX advances and captures `result`.
- **`flush`:** from any state, the next state is IDLE. `done` is not asserted for the aborted op, and `result` is unchanged. `flush` in IDLE blocks acceptance that cycle.
- **`start` outside IDLE:** ignored. No queuing.
- **`start` still high in the DONE cycle:** ignored. The same instruction is not restarted, because EX leaves in DONE.
- **Reset values:** state = IDLE, `busy` = 0, `done` = 0, `result` = 0, `cnt` = 0, internal regs = 0.
- **`arst_n` asserted mid-CALC:** immediate return to IDLE, no `done`.

## Timing
- **Normal op, accepted at edge 0:**
  - CALC occupies cycles 1–32.
  - DONE in cycle 33: `done` = 1 and `result` valid.
  - Total latency is 33 cycles after acceptance, with 33 cycles of `stall` (cycles 0–32).
- **Special case:** DONE in cycle 1, so latency is 1 cycle with `stall` high only in cycle 0.
- **`busy`:** high from cycle 1 through the DONE cycle inclusive.
- **Back-to-back ops:** a new `start` is accepted in the cycle after DONE at the earliest. Minimum spacing is 34 cycles for normal ops and 2 for special cases.
- **`flush` in cycle k:** IDLE at k+1, `stall` = 0 at k+1.

## Test plan
- **Unsigned divide:** DIVU 100/7 → `done` at cycle 33, `result` = 14. REMU 100/7 → 2. `stall` high for exactly cycles 0–32.
- **Signed divide:** DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). REM 7/−2 → 1.
- **Divide by zero:** DIVU 0x1234/0 → 0xFFFFFFFF. REM 0x1234/0 → 0x1234. `done` in cycle 1.
- **Signed overflow:** DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0. Latency 1. DIVU of the same operands takes 33 cycles → 0x00000000.
- **Flush:** `flush` at cycle 10 of CALC → IDLE and `busy` = 0 next cycle, no `done`, `result` unchanged. A new DIVU 9/3 is then accepted → 3.
- **Reset:** deassert `arst_n` in cycle 20 of CALC → outputs at reset values immediately. After release, DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
